pong_vga_renderer: RTL and testbench



---
 rtl/pong_pkg.sv | 43 ++++
 rtl/pong_vga_renderer_timing.sv | 64 ++++++
 rtl/pong_vga_renderer.sv | 161 ++++++++++++++++
 tb/tb_pong_vga_renderer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// pong_pkg
// Shared definitions for the Pong display path: default VGA 640x480@60 timing,
// the 10-bit screen coordinate type, the packed 2-bit-per-channel colour type,
// the colour palette, and the power-on shadow positions.
// No ports (package).
package pong_pkg;

  // Screen coordinate, wide enough for both counters (0..799 and 0..524).
  typedef logic [9:0] coord_t;

  // One pixel colour, 2 bits per channel, packed as {r, g, b}.
  typedef struct packed {
    logic [1:0] r;
    logic [1:0] g;
    logic [1:0] b;
  } rgb_t;

  // Default 640x480@60 timing (25.175 MHz pixel clock).
  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  // Colour palette.
  localparam rgb_t COL_BALL   = '{r: 2'd3, g: 2'd3, b: 2'd3};
  localparam rgb_t COL_PADDLE = '{r: 2'd0, g: 2'd3, b: 2'd0};
  localparam rgb_t COL_NET    = '{r: 2'd1, g: 2'd1, b: 2'd1};
  localparam rgb_t COL_BG     = '{r: 2'd0, g: 2'd0, b: 2'd0};

  // The net is two pixels wide, straddling the screen centre.
  localparam coord_t NET_X0 = 10'd319;
  localparam coord_t NET_X1 = 10'd320;

  // Shadow positions before the first snapshot: ball centred, paddle centred.
  localparam coord_t RST_BALL_X   = 10'd320;
  localparam coord_t RST_BALL_Y   = 10'd240;
  localparam coord_t RST_PADDLE_Y = 10'd210;

endpackage

// File: rtl/pong_vga_renderer_timing.sv
// vga_timing
// Free-running horizontal/vertical raster counters plus the combinational
// decodes derived from them. All decodes describe the current counter state;
// the renderer registers them so they stay aligned with the pixel colour.
// Ports:
//   clk, rst_n   pixel clock, asynchronous active-low reset
//   o_h_cnt      current column, 0 .. H_TOTAL-1
//   o_v_cnt      current line,   0 .. V_TOTAL-1
//   o_visible    counters are inside the visible region
//   o_hsync_n    horizontal sync level (active-low)
//   o_vsync_n    vertical sync level (active-low)
//   o_snap       first cycle of vertical blanking, i.e. counters at (0, V_ACTIVE)
module vga_timing
  import pong_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [9:0] o_h_cnt,
  output logic [9:0] o_v_cnt,
  output logic       o_visible,
  output logic       o_hsync_n,
  output logic       o_vsync_n,
  output logic       o_snap
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  coord_t r_h_cnt;
  coord_t r_v_cnt;

  // Raster scan: the column counter wraps every line and carries into the
  // line counter, which wraps once per frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (r_h_cnt == coord_t'(H_TOTAL - 1)) begin
      r_h_cnt <= '0;
      r_v_cnt <= (r_v_cnt == coord_t'(V_TOTAL - 1)) ? '0 : r_v_cnt + 10'd1;
    end else begin
      r_h_cnt <= r_h_cnt + 10'd1;
    end
  end

  assign o_h_cnt   = r_h_cnt;
  assign o_v_cnt   = r_v_cnt;
  assign o_visible = (r_h_cnt < coord_t'(H_ACTIVE)) && (r_v_cnt < coord_t'(V_ACTIVE));
  assign o_hsync_n = !((r_h_cnt >= coord_t'(H_ACTIVE + H_FP)) &&
                       (r_h_cnt <  coord_t'(H_ACTIVE + H_FP + H_SYNC)));
  assign o_vsync_n = !((r_v_cnt >= coord_t'(V_ACTIVE + V_FP)) &&
                       (r_v_cnt <  coord_t'(V_ACTIVE + V_FP + V_SYNC)));
  assign o_snap    = (r_h_cnt == '0) && (r_v_cnt == coord_t'(V_ACTIVE));

endmodule

// File: rtl/pong_vga_renderer.sv
// pong_vga_renderer
// Draws the Pong playfield onto a VGA raster. Game positions are captured into
// shadow registers once per frame at the start of vertical blanking so the
// visible image never tears; each pixel is then coloured by hit-testing the
// ball, paddle and net against the shadow positions. All outputs are
// registered and share one cycle of latency from the raster counters.
// Ports:
//   clk, rst_n             pixel clock, asynchronous active-low reset
//   i_ball_x, i_ball_y     ball top-left corner (game coordinates)
//   i_paddle_y             paddle top edge; paddle spans columns 0..PADDLE_WIDTH-1
//   o_hsync, o_vsync       active-low sync pulses
//   o_red/o_green/o_blue   2-bit colour channels, 0 outside the visible region
//   o_active               pixel on the outputs is visible
//   o_frame_tick           one-cycle pulse, shadow positions just reloaded
module pong_vga_renderer
  import pong_pkg::*;
#(
  parameter int H_ACTIVE      = H_ACTIVE_DEF,
  parameter int H_FP          = H_FP_DEF,
  parameter int H_SYNC        = H_SYNC_DEF,
  parameter int H_BP          = H_BP_DEF,
  parameter int V_ACTIVE      = V_ACTIVE_DEF,
  parameter int V_FP          = V_FP_DEF,
  parameter int V_SYNC        = V_SYNC_DEF,
  parameter int V_BP          = V_BP_DEF,
  parameter int BALL_SIZE     = 10,
  parameter int PADDLE_WIDTH  = 10,
  parameter int PADDLE_HEIGHT = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] i_ball_x,
  input  logic [9:0] i_ball_y,
  input  logic [9:0] i_paddle_y,
  output logic       o_hsync,
  output logic       o_vsync,
  output logic [1:0] o_red,
  output logic [1:0] o_green,
  output logic [1:0] o_blue,
  output logic       o_active,
  output logic       o_frame_tick
);

  coord_t w_h_cnt;
  coord_t w_v_cnt;
  logic   w_visible;
  logic   w_hsync_n;
  logic   w_vsync_n;
  logic   w_snap;

  vga_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk       (clk),
    .rst_n     (rst_n),
    .o_h_cnt   (w_h_cnt),
    .o_v_cnt   (w_v_cnt),
    .o_visible (w_visible),
    .o_hsync_n (w_hsync_n),
    .o_vsync_n (w_vsync_n),
    .o_snap    (w_snap)
  );

  coord_t r_ball_x;
  coord_t r_ball_y;
  coord_t r_paddle_y;

  // Shadow positions: the game inputs are only looked at on the snapshot
  // cycle, so a position change mid-frame shows up in the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ball_x   <= RST_BALL_X;
      r_ball_y   <= RST_BALL_Y;
      r_paddle_y <= RST_PADDLE_Y;
    end else if (w_snap) begin
      r_ball_x   <= i_ball_x;
      r_ball_y   <= i_ball_y;
      r_paddle_y <= i_paddle_y;
    end
  end

  // Hit tests widened to 11 bits so position + size can never wrap; a ball
  // near the right edge therefore just runs off-screen instead of reappearing
  // at column 0.
  logic [10:0] w_x;
  logic [10:0] w_y;
  logic        w_ball_hit;
  logic        w_paddle_hit;
  logic        w_net_hit;

  assign w_x = {1'b0, w_h_cnt};
  assign w_y = {1'b0, w_v_cnt};

  assign w_ball_hit = (w_x >= {1'b0, r_ball_x}) &&
                      (w_x <  {1'b0, r_ball_x} + 11'(BALL_SIZE)) &&
                      (w_y >= {1'b0, r_ball_y}) &&
                      (w_y <  {1'b0, r_ball_y} + 11'(BALL_SIZE));

  assign w_paddle_hit = (w_x <  11'(PADDLE_WIDTH)) &&
                        (w_y >= {1'b0, r_paddle_y}) &&
                        (w_y <  {1'b0, r_paddle_y} + 11'(PADDLE_HEIGHT));

  // Dashed net: 8 lines drawn, 8 lines skipped.
  assign w_net_hit = ((w_h_cnt == NET_X0) || (w_h_cnt == NET_X1)) && !w_v_cnt[3];

  rgb_t w_pixel;

  // Priority mux; blanking forces black whatever the hit tests say.
  always_comb begin
    w_pixel = COL_BG;
    if (w_visible) begin
      if (w_ball_hit) begin
        w_pixel = COL_BALL;
      end else if (w_paddle_hit) begin
        w_pixel = COL_PADDLE;
      end else if (w_net_hit) begin
        w_pixel = COL_NET;
      end
    end
  end

  logic r_hsync;
  logic r_vsync;
  rgb_t r_pixel;
  logic r_active;
  logic r_frame_tick;

  // Output stage: every output goes through one register so sync, active
  // and colour leave the block on the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hsync      <= 1'b1;
      r_vsync      <= 1'b1;
      r_pixel      <= COL_BG;
      r_active     <= 1'b0;
      r_frame_tick <= 1'b0;
    end else begin
      r_hsync      <= w_hsync_n;
      r_vsync      <= w_vsync_n;
      r_pixel      <= w_pixel;
      r_active     <= w_visible;
      r_frame_tick <= w_snap;
    end
  end

  assign o_hsync      = r_hsync;
  assign o_vsync      = r_vsync;
  assign o_red        = r_pixel.r;
  assign o_green      = r_pixel.g;
  assign o_blue       = r_pixel.b;
  assign o_active     = r_active;
  assign o_frame_tick = r_frame_tick;

endmodule

// File: tb/tb_pong_vga_renderer.sv
// tb_pong_vga_renderer
// Self-checking bench for pong_vga_renderer. The vertical timing and paddle
// height are shrunk so several whole frames fit in a short run; horizontal
// timing stays at the full 800-column line so the net and right-edge clipping
// are exercised at their real columns. A behavioural model tracks the raster
// position and the shadow positions and predicts every output on every cycle.
module tb_pong_vga_renderer;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int V_ACTIVE = 16;
  localparam int V_FP     = 1;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 1;
  localparam int BALL     = 10;
  localparam int PW       = 10;
  localparam int PH       = 8;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [5:0] WHITE = 6'h3F;
  localparam logic [5:0] GREEN = 6'h0C;
  localparam logic [5:0] GREY  = 6'h15;
  localparam logic [5:0] BLACK = 6'h00;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] ballX;
  logic [9:0] ballY;
  logic [9:0] paddleY;
  logic       hsync;
  logic       vsync;
  logic [1:0] red;
  logic [1:0] green;
  logic [1:0] blue;
  logic       active;
  logic       frameTick;

  pong_vga_renderer #(
    .H_ACTIVE      (H_ACTIVE),
    .H_FP          (H_FP),
    .H_SYNC        (H_SYNC),
    .H_BP          (H_BP),
    .V_ACTIVE      (V_ACTIVE),
    .V_FP          (V_FP),
    .V_SYNC        (V_SYNC),
    .V_BP          (V_BP),
    .BALL_SIZE     (BALL),
    .PADDLE_WIDTH  (PW),
    .PADDLE_HEIGHT (PH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_ball_x     (ballX),
    .i_ball_y     (ballY),
    .i_paddle_y   (paddleY),
    .o_hsync      (hsync),
    .o_vsync      (vsync),
    .o_red        (red),
    .o_green      (green),
    .o_blue       (blue),
    .o_active     (active),
    .o_frame_tick (frameTick)
  );

  // 25.175 MHz is not needed for checking; any period works.
  always #5 clk = ~clk;

  int checksTotal  = 0;
  int checksPassed = 0;
  int checksFailed = 0;

  // Model state: raster position the DUT counters hold right now, the pixel
  // currently shown on the outputs, and the shadow positions.
  int mh, mv;
  int shownX, shownY;
  int shBx, shBy, shPy;

  // Per-frame pulse accounting and cumulative per-cycle deviations.
  int hsLow, vsLow, tickCnt;
  bit windowFull;
  int rgbBad, syncBad, activeBad, tickBad;

  int randBy, randPy;

  function automatic logic [5:0] expectedRgb(input int x, input int y);
    if (x >= H_ACTIVE || y >= V_ACTIVE) return BLACK;
    if (x >= shBx && x < shBx + BALL && y >= shBy && y < shBy + BALL) return WHITE;
    if (x < PW && y >= shPy && y < shPy + PH) return GREEN;
    if ((x == 319 || x == 320) && ((y / 8) % 2 == 0)) return GREY;
    return BLACK;
  endfunction

  function automatic logic [5:0] observedRgb();
    return {red, green, blue};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checksTotal++;
    assert (observed === expected) begin
      checksPassed++;
    end else begin
      checksFailed++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int bx, input int by, input int py);
    ballX   = 10'(bx);
    ballY   = 10'(by);
    paddleY = 10'(py);
  endtask

  task automatic modelReset();
    mh = 0; mv = 0;
    shBx = 320; shBy = 240; shPy = 210;
    hsLow = 0; vsLow = 0; tickCnt = 0;
    windowFull = 0;
  endtask

  // Advance one clock and compare everything the DUT shows against the model.
  task automatic stepCycle();
    bit snapNow;
    bit hsExp, vsExp, actExp;
    @(posedge clk);
    snapNow = (mh == 0 && mv == V_ACTIVE);
    if (snapNow) begin
      shBx = int'(ballX); shBy = int'(ballY); shPy = int'(paddleY);
    end
    shownX = mh; shownY = mv;
    if (mh == H_TOTAL - 1) begin
      mh = 0;
      mv = (mv == V_TOTAL - 1) ? 0 : mv + 1;
    end else begin
      mh = mh + 1;
    end
    #1;
    if (snapNow) begin
      if (windowFull) begin
        checkOutput("hsync low cycles per frame", hsLow, H_SYNC * V_TOTAL);
        checkOutput("vsync low cycles per frame", vsLow, V_SYNC * H_TOTAL);
        checkOutput("frame_tick pulses per frame", tickCnt, 1);
      end
      hsLow = 0; vsLow = 0; tickCnt = 0;
      windowFull = 1;
    end
    if (hsync === 1'b0) hsLow++;
    if (vsync === 1'b0) vsLow++;
    if (frameTick === 1'b1) tickCnt++;
    hsExp  = !(shownX >= H_ACTIVE + H_FP && shownX < H_ACTIVE + H_FP + H_SYNC);
    vsExp  = !(shownY >= V_ACTIVE + V_FP && shownY < V_ACTIVE + V_FP + V_SYNC);
    actExp = (shownX < H_ACTIVE) && (shownY < V_ACTIVE);
    if (observedRgb() !== expectedRgb(shownX, shownY)) rgbBad++;
    if (hsync !== hsExp || vsync !== vsExp) syncBad++;
    if (active !== actExp) activeBad++;
    if (frameTick !== snapNow) tickBad++;
  endtask

  // Step until the outputs show pixel (x,y); bounded by a little over a frame.
  task automatic runTo(input int x, input int y);
    int n;
    bit found;
    n = 0;
    found = 0;
    while (!found && n < H_TOTAL * V_TOTAL + 100) begin
      stepCycle();
      n++;
      if (shownX == x && shownY == y) found = 1;
    end
    checkOutput($sformatf("reach pixel (%0d,%0d)", x, y), found, 1);
  endtask

  initial begin
    rgbBad = 0; syncBad = 0; activeBad = 0; tickBad = 0;
    rst_n = 1'b0;
    applyStimulus(100, 4, 0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset hsync", hsync, 1);
    checkOutput("reset vsync", vsync, 1);
    checkOutput("reset rgb", observedRgb(), BLACK);
    checkOutput("reset active", active, 0);
    checkOutput("reset frame_tick", frameTick, 0);
    rst_n = 1'b1;
    modelReset();
    $display("[TB] reset released, frame 0 uses power-on shadow positions");

    // Frame 0: ball and paddle parked off-screen, only the net shows.
    runTo(0, 0);
    checkOutput("first pixel active", active, 1);
    checkOutput("first pixel black", observedRgb(), BLACK);
    runTo(319, 0);   checkOutput("net col 319", observedRgb(), GREY);
    runTo(320, 0);   checkOutput("net col 320", observedRgb(), GREY);
    runTo(321, 0);   checkOutput("beside net", observedRgb(), BLACK);
    runTo(640, 0);   checkOutput("h blank active", active, 0);
    runTo(319, 8);   checkOutput("net gap", observedRgb(), BLACK);
    runTo(0, V_ACTIVE);
    checkOutput("frame_tick at snapshot", frameTick, 1);

    // Frame 1: ball (100,4), paddle at top.
    runTo(0, 0);     checkOutput("paddle top-left", observedRgb(), GREEN);
    runTo(10, 0);    checkOutput("right of paddle", observedRgb(), BLACK);
    runTo(100, 4);   checkOutput("ball top-left", observedRgb(), WHITE);
    runTo(110, 4);   checkOutput("right of ball", observedRgb(), BLACK);
    runTo(9, 7);     checkOutput("paddle bottom-right", observedRgb(), GREEN);
    runTo(0, 8);     checkOutput("below paddle", observedRgb(), BLACK);
    applyStimulus(0, 0, 0);
    runTo(5, 10);    checkOutput("mid-frame change ignored (new spot)", observedRgb(), BLACK);
    runTo(100, 10);  checkOutput("mid-frame change ignored (old spot)", observedRgb(), WHITE);
    runTo(109, 13);  checkOutput("ball bottom-right", observedRgb(), WHITE);
    runTo(100, 14);  checkOutput("below ball", observedRgb(), BLACK);

    // Frame 2: ball at origin overlapping the paddle.
    runTo(5, 5);     checkOutput("ball over paddle", observedRgb(), WHITE);
    runTo(0, 8);
    randBy = $urandom_range(0, 9);
    randPy = $urandom_range(0, 15);
    applyStimulus(635, randBy, randPy);
    runTo(9, 9);     checkOutput("ball origin bottom-right", observedRgb(), WHITE);
    runTo(5, 10);    checkOutput("below origin ball", observedRgb(), BLACK);
    runTo(100, 10);  checkOutput("old ball position cleared", observedRgb(), BLACK);

    // Frame 3: ball clipped at the right edge, random row and paddle.
    $display("[TB] frame 3 ball_y=%0d paddle_y=%0d", randBy, randPy);
    runTo(0, randBy);
    checkOutput("no wrap to column 0", observedRgb(),
                (randBy >= randPy && randBy < randPy + PH) ? GREEN : BLACK);
    runTo(635, randBy);  checkOutput("edge ball col 635", observedRgb(), WHITE);
    runTo(639, randBy);  checkOutput("edge ball col 639", observedRgb(), WHITE);
    runTo(640, randBy);  checkOutput("edge ball clipped rgb", observedRgb(), BLACK);
    checkOutput("edge ball clipped active", active, 0);

    // Asynchronous reset in the middle of an hsync pulse.
    runTo(700, 12);
    checkOutput("hsync low before reset", hsync, 0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset hsync", hsync, 1);
    checkOutput("async reset vsync", vsync, 1);
    checkOutput("async reset active", active, 0);
    checkOutput("async reset rgb", observedRgb(), BLACK);
    checkOutput("async reset frame_tick", frameTick, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    modelReset();
    stepCycle();
    checkOutput("post-reset pixel (0,0) active", active, 1);
    checkOutput("post-reset pixel (0,0) rgb", observedRgb(), BLACK);
    runTo(320, 0);   checkOutput("post-reset net", observedRgb(), GREY);
    runTo(700, 0);   checkOutput("post-reset hsync low", hsync, 0);

    checkOutput("per-cycle rgb deviations", rgbBad, 0);
    checkOutput("per-cycle sync deviations", syncBad, 0);
    checkOutput("per-cycle active deviations", activeBad, 0);
    checkOutput("per-cycle frame_tick deviations", tickBad, 0);

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
